// File: rtl/deser_queue_top.sv
// Serial-to-parallel front end: LSB-first bit deserializer feeding an 8 x 8 byte FIFO.
// The write and dequeue strobes act only on their rising edges.
module deser_queue_top (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write_in,
  input  logic       dequeue_in,
  output logic       status_out,
  output logic [3:0] len_out,
  output logic [7:0] data_out
);

  logic       write_in_q;
  logic       dequeue_in_q;
  logic       wr_edge;
  logic       deq_edge;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       pending;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic [7:0] mem [8];
  logic       full;
  logic       accept_bit;
  logic       do_pop;

  assign wr_edge    = write_in & ~write_in_q;
  assign deq_edge   = dequeue_in & ~dequeue_in_q;
  assign full       = (count == 4'd8);
  assign accept_bit = wr_edge & ~full;
  assign do_pop     = deq_edge & (count != 4'd0);
  assign len_out    = count;

  // The completed byte stays in shift_reg during the push cycle.
  // No new bit can land there because an edge needs a low cycle first.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_in_q   <= 1'b0;
      dequeue_in_q <= 1'b0;
      bit_cnt      <= 3'd0;
      shift_reg    <= 8'h00;
      pending      <= 1'b0;
      wr_ptr       <= 3'd0;
      rd_ptr       <= 3'd0;
      count        <= 4'd0;
      data_out     <= 8'h00;
      status_out   <= 1'b0;
    end else begin
      write_in_q   <= write_in;
      dequeue_in_q <= dequeue_in;

      if (accept_bit) begin
        shift_reg[bit_cnt] <= data_in;
        bit_cnt            <= bit_cnt + 3'd1;
      end
      pending <= accept_bit && (bit_cnt == 3'd7);

      if (pending) begin
        wr_ptr <= wr_ptr + 3'd1;
      end

      if (do_pop) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 3'd1;
      end

      case ({pending, do_pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase

      status_out <= (bit_cnt == 3'd0) && !pending && !full;
    end
  end

  always_ff @(posedge clock) begin
    if (pending) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

endmodule

// File: tb/tb_deser_queue_top.sv
// Directed bench for deser_queue_top: reset, byte assembly, pops, full FIFO,
// pointer wrap and reset in the middle of a byte.
module tb_deser_queue_top;

  logic       clock;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       dequeue_in;
  logic       status_out;
  logic [3:0] len_out;
  logic [7:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  deser_queue_top dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .dequeue_in (dequeue_in),
    .status_out (status_out),
    .len_out    (len_out),
    .data_out   (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock);
    data_in  = b;
    write_in = 1'b1;
    repeat (10) @(negedge clock);
    write_in = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic pop_pulse();
    @(negedge clock);
    dequeue_in = 1'b1;
    repeat (10) @(negedge clock);
    dequeue_in = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check({tag, "_status"}, {7'd0, status_out}, 8'h00);
    check({tag, "_len"},    {4'd0, len_out},    8'h00);
    check({tag, "_data"},   data_out,           8'h00);
    reset = 1'b0;
    @(negedge clock);
    check({tag, "_status_up"}, {7'd0, status_out}, 8'h01);
  endtask

  initial begin
    reset      = 1'b0;
    data_in    = 1'b0;
    write_in   = 1'b0;
    dequeue_in = 1'b0;

    do_reset("rst");

    // Single byte 0x99 with cycle-accurate checks on the first and last bit
    @(negedge clock);
    data_in  = 1'b1;
    write_in = 1'b1;
    @(negedge clock);
    check("st_after_first_edge", {7'd0, status_out}, 8'h01);
    @(negedge clock);
    check("st_fall", {7'd0, status_out}, 8'h00);
    repeat (8) @(negedge clock);
    write_in = 1'b0;
    repeat (10) @(negedge clock);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    @(negedge clock);
    data_in  = 1'b1;
    write_in = 1'b1;
    @(negedge clock);
    check("len_pending", {4'd0, len_out}, 8'h00);
    @(negedge clock);
    check("len_push", {4'd0, len_out}, 8'h01);
    check("st_push", {7'd0, status_out}, 8'h00);
    @(negedge clock);
    check("st_rerise", {7'd0, status_out}, 8'h01);
    repeat (7) @(negedge clock);
    write_in = 1'b0;
    repeat (10) @(negedge clock);

    // Second byte and two pops
    send_byte(8'hF0);
    check("len_two", {4'd0, len_out}, 8'h02);
    pop_pulse();
    check("pop1_data", data_out, 8'h99);
    check("pop1_len", {4'd0, len_out}, 8'h01);
    pop_pulse();
    check("pop2_data", data_out, 8'hF0);
    check("pop2_len", {4'd0, len_out}, 8'h00);

    // Pop on empty
    pop_pulse();
    check("empty_data", data_out, 8'hF0);
    check("empty_len", {4'd0, len_out}, 8'h00);

    // Fill, overflow attempt, drain across the pointer wrap
    for (int v = 1; v <= 8; v++) send_byte(8'(v));
    check("full_len", {4'd0, len_out}, 8'h08);
    check("full_status", {7'd0, status_out}, 8'h00);
    send_byte(8'hFF);
    check("ovf_len", {4'd0, len_out}, 8'h08);
    check("ovf_status", {7'd0, status_out}, 8'h00);
    pop_pulse();
    check("drain1_data", data_out, 8'h01);
    check("drain1_len", {4'd0, len_out}, 8'h07);
    check("drain1_status", {7'd0, status_out}, 8'h01);
    for (int v = 2; v <= 8; v++) begin
      pop_pulse();
      check($sformatf("drain%0d_data", v), data_out, 8'(v));
    end
    check("drained_len", {4'd0, len_out}, 8'h00);

    // Reset with a stored byte and a partial byte in flight
    send_byte(8'h3C);
    check("pre_rst_len", {4'd0, len_out}, 8'h01);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset("midrst");
    send_byte(8'hA5);
    check("post_rst_len", {4'd0, len_out}, 8'h01);
    pop_pulse();
    check("post_rst_data", data_out, 8'hA5);
    check("post_rst_len0", {4'd0, len_out}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
